// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types, constants and byte-lane merge helper for pwm_bank
// Contents:
//   pwm_mode_t  : PWM_EDGE (0) / PWM_CENTER (1)
//   dir_t       : center-mode counting direction
//   LANE_W      : width of one byte lane
//   MAX_W       : widest register lane_merge() handles (W must not exceed it)
//   lane_merge(): replaces the lanes of old_v selected by be with those of new_v
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int LANE_W    = 8;
  localparam int MAX_W     = 64;
  localparam int MAX_LANES = MAX_W / LANE_W;

  // Callers zero-extend narrower operands into MAX_W and truncate the result.
  function automatic logic [MAX_W-1:0] lane_merge(
    input logic [MAX_W-1:0]     old_v,
    input logic [MAX_W-1:0]     new_v,
    input logic [MAX_LANES-1:0] be
  );
    logic [MAX_W-1:0] r;
    r = old_v;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (be[k]) begin
        r[k*LANE_W +: LANE_W] = new_v[k*LANE_W +: LANE_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: duty shadow/active registers and registered compare
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   wr           : duty write strobe already qualified for this channel
//   wr_data      : write data, byte_en selects which lanes are replaced
//   load         : active <- (shadow merged with this cycle's write) on the next edge
//   run          : counter is running with a non-zero period
//   cnt          : shared period counter
//   cmp          : registered (run && cnt < duty_act)
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [W-1:0]        wr_data,
  input  logic [W/LANE_W-1:0] byte_en,
  input  logic                load,
  input  logic                run,
  input  logic [W-1:0]        cnt,
  output logic                cmp
);

  logic [W-1:0] duty_sh;
  logic [W-1:0] duty_act;
  logic [W-1:0] duty_nx;

  // Next shadow value; also what the active register takes on a load, so a
  // write landing in the boundary cycle is already part of the new period.
  always_comb begin
    duty_nx = duty_sh;
    if (wr) begin
      duty_nx = W'(lane_merge(MAX_W'(duty_sh), MAX_W'(wr_data), MAX_LANES'(byte_en)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_sh  <= '0;
      duty_act <= '0;
      cmp      <= 1'b0;
    end else begin
      duty_sh <= duty_nx;
      if (load) begin
        duty_act <= duty_nx;
      end
      cmp <= run && (cnt < duty_act);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM with shared counter and boundary-loaded shadow registers
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   enable       : run the counter; low holds cnt at 0 and drives outputs inactive
//   duty_wr      : write duty shadow of channel duty_ch (duty_ch >= N_CH ignored)
//   duty_ch      : duty write target channel
//   period_wr    : write period shadow
//   wr_data      : write data for duty or period
//   byte_en      : per-byte lane mask for wr_data
//   mode_in      : 0 edge-aligned, 1 center-aligned (sampled into the shadow every cycle)
//   polarity     : per-channel output inversion
//   pwm_out      : PWM outputs
//   cycle_start  : high in the first cycle of each new PWM period
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 16,
  parameter int CH_AW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                duty_wr,
  input  logic [CH_AW-1:0]    duty_ch,
  input  logic                period_wr,
  input  logic [W-1:0]        wr_data,
  input  logic [W/LANE_W-1:0] byte_en,
  input  logic                mode_in,
  input  logic [N_CH-1:0]     polarity,
  output logic [N_CH-1:0]     pwm_out,
  output logic                cycle_start
);

  logic [W-1:0]    period_sh;
  logic [W-1:0]    period_act;
  logic [W-1:0]    period_nx;
  logic [W-1:0]    cnt;
  pwm_mode_t       mode_sh;
  pwm_mode_t       mode_act;
  dir_t            dir;
  logic            run;
  logic            at_top;
  logic            bnd;
  logic            load;
  logic [N_CH-1:0] cmp_q;

  always_comb begin
    period_nx = period_sh;
    if (period_wr) begin
      period_nx = W'(lane_merge(MAX_W'(period_sh), MAX_W'(wr_data), MAX_LANES'(byte_en)));
    end
  end

  assign run    = enable && (period_act != '0);
  assign at_top = (cnt == period_act - W'(1));

  always_comb begin
    bnd = 1'b0;
    if (run) begin
      if (mode_act == PWM_EDGE) begin
        bnd = at_top;
      end else begin
        bnd = (dir == DIR_DOWN) && (cnt == '0);
      end
    end
  end

  // While stopped (disabled or zero period) the active set follows the shadow
  // every cycle, so restarting always begins with the latest programming.
  assign load = !run || bnd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_sh   <= '0;
      period_act  <= '0;
      mode_sh     <= PWM_EDGE;
      mode_act    <= PWM_EDGE;
      cnt         <= '0;
      dir         <= DIR_UP;
      cycle_start <= 1'b0;
    end else begin
      period_sh   <= period_nx;
      mode_sh     <= pwm_mode_t'(mode_in);
      cycle_start <= bnd;
      if (load) begin
        period_act <= period_nx;
        mode_act   <= mode_sh;
        cnt        <= '0;
        dir        <= DIR_UP;
      end else if (mode_act == PWM_EDGE) begin
        cnt <= cnt + W'(1);
      end else if (dir == DIR_UP) begin
        // The top value is held for two cycles: once going up, once going down.
        if (at_top) begin
          dir <= DIR_DOWN;
        end else begin
          cnt <= cnt + W'(1);
        end
      end else begin
        cnt <= cnt - W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel #(
      .W(W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr      (duty_wr && (duty_ch == CH_AW'(i))),
      .wr_data (wr_data),
      .byte_en (byte_en),
      .load    (load),
      .run     (run),
      .cnt     (cnt),
      .cmp     (cmp_q[i])
    );
  end

  assign pwm_out = cmp_q ^ polarity;

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - self-checking bench for pwm_bank (period-position model plus directed literals)
module tb_pwm_bank;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         duty_wr;
  logic [1:0]   duty_ch;
  logic         period_wr;
  logic [W-1:0] wr_data;
  logic [1:0]   byte_en;
  logic         mode_in;
  logic [N-1:0] polarity;
  logic [N-1:0] pwm_out;
  logic         cycle_start;

  int total = 0;
  int bad   = 0;

  pwm_bank #(.N_CH(N), .W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .duty_wr     (duty_wr),
    .duty_ch     (duty_ch),
    .period_wr   (period_wr),
    .wr_data     (wr_data),
    .byte_en     (byte_en),
    .mode_in     (mode_in),
    .polarity    (polarity),
    .pwm_out     (pwm_out),
    .cycle_start (cycle_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int merge16(input int old_v, input int new_v, input logic [1:0] be);
    int m;
    m = (be[0] ? 'h00FF : 0) | (be[1] ? 'hFF00 : 0);
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Model: position t within a period of length P (edge) or 2P (center);
  // the counter value seen by the comparators is t, or its mirror on the way down.
  int         m_dsh [N];
  int         m_dact[N];
  int         m_psh  = 0;
  int         m_pact = 0;
  bit         m_msh  = 1'b0;
  bit         m_mact = 1'b0;
  int         m_t    = 0;
  logic [N-1:0] exp_cmp = '0;
  logic       exp_cs  = 1'b0;

  initial begin
    int  dnx[N];
    int  pnx, mlen, mpos;
    bit  mrun, mbnd;
    for (int i = 0; i < N; i++) begin
      m_dsh[i]  = 0;
      m_dact[i] = 0;
    end
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int i = 0; i < N; i++) begin
          m_dsh[i]  = 0;
          m_dact[i] = 0;
        end
        m_psh = 0; m_pact = 0; m_msh = 1'b0; m_mact = 1'b0; m_t = 0;
        exp_cmp = '0; exp_cs = 1'b0;
      end else begin
        mrun = enable && (m_pact != 0);
        mlen = m_mact ? 2 * m_pact : m_pact;
        mpos = (m_mact && m_t >= m_pact) ? 2 * m_pact - 1 - m_t : m_t;
        mbnd = mrun && (m_t == mlen - 1);
        for (int i = 0; i < N; i++) begin
          exp_cmp[i] = mrun && (mpos < m_dact[i]);
          dnx[i] = (duty_wr && duty_ch == 2'(i)) ? merge16(m_dsh[i], int'(wr_data), byte_en) : m_dsh[i];
        end
        pnx = period_wr ? merge16(m_psh, int'(wr_data), byte_en) : m_psh;
        exp_cs = mbnd;
        if (!mrun || mbnd) begin
          for (int i = 0; i < N; i++) m_dact[i] = dnx[i];
          m_pact = pnx;
          m_mact = m_msh;
          m_t    = 0;
        end else begin
          m_t = m_t + 1;
        end
        for (int i = 0; i < N; i++) m_dsh[i] = dnx[i];
        m_psh = pnx;
        m_msh = mode_in;
      end
    end
  end

  initial begin
    #3;
    forever begin
      @(negedge clk);
      check("pwm_cycle", 32'(pwm_out), 32'(exp_cmp ^ polarity));
      check("cs_cycle", 32'(cycle_start), 32'(exp_cs));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr_duty(input int ch, input int val, input logic [1:0] be);
    duty_ch = 2'(ch); wr_data = 16'(val); byte_en = be; duty_wr = 1'b1;
    cyc(1);
    duty_wr = 1'b0; byte_en = 2'b11;
  endtask

  task automatic wr_period(input int val);
    wr_data = 16'(val); byte_en = 2'b11; period_wr = 1'b1;
    cyc(1);
    period_wr = 1'b0;
  endtask

  task automatic wait_cs(input int bound);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cycle_start && k < bound);
    check("cs_wait", 32'(cycle_start), 32'd1);
    #1;
  endtask

  task automatic cs_gap(output int g);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!cycle_start && g < 100);
    #1;
  endtask

  // Counts high samples of pwm_out[ch] over len cycles starting just after a
  // cycle_start; optionally writes duty0 = wr_val during the cycle with cnt = wr_at.
  task automatic run_period(input int ch, input int len, input int wr_at, input int wr_val,
                            output int n);
    n = 0;
    for (int j = 1; j <= len; j++) begin
      @(negedge clk);
      n += int'(pwm_out[ch]);
      #1;
      duty_ch = 2'd0; byte_en = 2'b11; wr_data = 16'(wr_val);
      duty_wr = (j == wr_at);
    end
    duty_wr = 1'b0;
  endtask

  initial begin
    int n, g, ncs, nhi;
    reset = 1'b1; enable = 1'b0; duty_wr = 1'b0; duty_ch = 2'd0; period_wr = 1'b0;
    wr_data = '0; byte_en = 2'b11; mode_in = 1'b0; polarity = '0;
    #2 reset = 1'b0;
    cyc(3);
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_cs", 32'(cycle_start), 32'd0);
    reset = 1'b1;
    cyc(1);

    // edge-aligned basics
    wr_period(10);
    wr_duty(0, 3, 2'b11);
    wr_duty(1, 5, 2'b11);
    wr_duty(3, 12, 2'b11);
    enable = 1'b1;
    wait_cs(50);
    run_period(0, 10, 0, 0, n); check("edge_duty3", 32'(n), 32'd3);
    run_period(3, 10, 0, 0, n); check("duty_over_period", 32'(n), 32'd10);
    run_period(2, 10, 0, 0, n); check("duty_zero", 32'(n), 32'd0);
    cs_gap(g);                  check("edge_cs_gap", 32'(g), 32'd10);

    // shadow updates take effect only at the boundary
    run_period(0, 10, 4, 7, n); check("glitch_cur", 32'(n), 32'd3);
    run_period(0, 10, 0, 0, n); check("glitch_next", 32'(n), 32'd7);
    run_period(0, 10, 9, 2, n); check("bwrite_cur", 32'(n), 32'd7);
    run_period(0, 10, 0, 0, n); check("bwrite_next", 32'(n), 32'd2);

    // byte-lane merge: 0x1234 then 0xABCD on lane 0 only -> 0x12CD
    wr_duty(2, 'h1234, 2'b11);
    wr_duty(2, 'hABCD, 2'b01);
    wr_period('h12D0);
    wait_cs(6000);
    run_period(2, 'h12D0, 0, 0, n); check("byte_lane", 32'(n), 32'h12CD);

    // enable falling mid-period
    cyc(7);
    enable = 1'b0;
    cyc(2);
    check("disable_pwm", 32'(pwm_out), 32'd0);
    check("disable_cs", 32'(cycle_start), 32'd0);

    // center-aligned
    mode_in = 1'b1;
    wr_period(8);
    wr_duty(1, 2, 2'b11);
    cyc(2);
    enable = 1'b1;
    wait_cs(40);
    run_period(1, 16, 0, 0, n); check("center_duty", 32'(n), 32'd4);
    cs_gap(g);                  check("center_cs_gap", 32'(g), 32'd16);

    // zero period: no pulses, no cycle_start
    wr_period(0);
    wait_cs(40);
    ncs = 0; nhi = 0;
    repeat (40) begin
      @(negedge clk);
      ncs += int'(cycle_start);
      nhi += int'(|pwm_out);
      #1;
    end
    check("p0_cs", 32'(ncs), 32'd0);
    check("p0_pwm", 32'(nhi), 32'd0);

    // polarity on channel 3 only
    mode_in = 1'b0;
    cyc(2);
    polarity = 4'b1000;
    wr_duty(3, 0, 2'b11);
    wr_period(10);
    wait_cs(40);
    run_period(3, 10, 0, 0, n); check("pol_ch3", 32'(n), 32'd10);
    run_period(0, 10, 0, 0, n); check("pol_ch0", 32'(n), 32'd2);

    // asynchronous reset at cnt = 5
    cyc(5);
    reset = 1'b0;
    cyc(1);
    check("rst_mid_pwm", 32'(pwm_out), 32'h8);
    check("rst_mid_cs", 32'(cycle_start), 32'd0);
    reset = 1'b1;
    cyc(2);
    check("rst_after_pwm", 32'(pwm_out), 32'h8);
    wr_period(4);
    wr_duty(0, 1, 2'b11);
    wait_cs(40);
    run_period(0, 4, 0, 0, n); check("post_reset", 32'(n), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Multi-channel PWM generator with one shared period counter and N_CH independent duty-cycle comparators. It has byte-lane-maskable shadow registers that load into the active set only at a PWM cycle boundary, so reprogramming never produces a glitch. It supports edge-aligned and center-aligned modes and per-channel output polarity. It sits between the switch/bus register front-end and the board output pins. It replaces the single-channel 8-bit-lane PWM core.

## Interface
- N_CH, 4, number of PWM channels (1..16)
- W, 16, counter/duty/period width in bits; must be a multiple of 8
- CH_AW, $clog2(N_CH) (min 1), channel select width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run counter; when low, counter held and outputs at inactive level
- duty_wr  in  1  write strobe for duty shadow of channel duty_ch
- duty_ch  in  CH_AW  target channel; writes with duty_ch >= N_CH are ignored
- period_wr  in  1  write strobe for period shadow
- wr_data  in  W  write data for duty or period
- byte_en  in  W/8  lane mask; lane k covers wr_data[8k+7:8k]
- mode_in  in  1  0 = edge-aligned, 1 = center-aligned; shadowed
- polarity  in  N_CH  per-channel inversion, applied combinationally to the registered compare result
- pwm_out  out  N_CH  PWM outputs
- cycle_start  out  1  one-cycle pulse in the cycle the active registers load

## Operation
- State:
  - shadow regs: duty_sh[N_CH], period_sh, mode_sh
  - active regs: duty_act[N_CH], period_act, mode_act
  - counter cnt[W]
  - direction flag dir (UP/DOWN)
- Writes go to shadow only. Unmasked lanes keep their old value. duty_wr and period_wr in the same cycle both take effect.
- mode_sh samples mode_in every cycle.
- Edge mode:
  - cnt runs 0,1,…,P-1, then wraps, where P = period_act; cycle length is P.
  - Compare is cnt < duty_act: exactly duty high-active cycles.
- Center mode:
  - dir UP: cnt increments. At cnt == P-1, cnt holds and dir goes DOWN.
  - dir DOWN: cnt decrements. At cnt == 0, cnt holds and dir goes UP.
  - Cycle length is 2P. Compare is cnt < duty_act, giving 2·duty active cycles centered on the boundary.
- Boundary B is asserted when enable=1, P≠0, and either:
  - edge mode: cnt == P-1
  - center mode: dir == DOWN and cnt == 0
- On B, the next edge:
  - loads active ← shadow, merged with any write in the same cycle (the write wins per lane)
  - sets cnt ← 0, dir ← UP
  - sets cycle_start ← 1
- While enable=0:
  - cnt = 0, dir = UP
  - active ← shadow every cycle (the active set tracks the shadow set)
  - cycle_start = 0
- P = 0 while enabled: cnt held at 0, compare forced false, B never fires, and active keeps tracking shadow until P ≠ 0.
- duty_act ≥ P (edge) or ≥ P (center): output is permanently active. duty_act = 0: output is permanently inactive.
- pwm_out[i] = cmp_q[i] ^ polarity[i]. cmp_q[i] is the registered value of (enable && P ≠ 0 && cnt < duty_act[i]).
- Arithmetic is unsigned W-bit throughout; cnt never exceeds P-1.

## Timing
- Reset values:
  - all shadow, active, cnt, cmp_q, cycle_start = 0
  - dir = UP
  - pwm_out = polarity, which is 0 when polarity = 0
- Shadow write is visible in the shadow on the edge after the strobe.
- Compare-to-pin latency is 1 cycle: pwm_out reflects the cnt value of the previous cycle.
- cycle_start is high in the first cycle of the new PWM period (cnt = 0) and is never high for two consecutive cycles unless P = 1 in edge mode.
- Enable falling: cnt = 0 next edge, and pwm_out goes inactive one edge later.
- Enable rising: the first enabled cycle has cnt = 0 with active = the current shadow.
- Reset asserted mid-cycle clears everything immediately (asynchronously). The first period after release starts at cnt = 0.

## Structure
- Package pwm_pkg:
  - mode encoding (PWM_EDGE = 0, PWM_CENTER = 1)
  - LANE_W = 8
  - lane-merge function: old, new, byte_en → merged
- Sub-module pwm_channel: duty shadow/active regs, lane merge, compare, cmp_q flop. Instantiated N_CH times via generate.
- The top level holds the period/mode shadow regs, counter, direction, boundary logic and cycle_start.

## Test plan
- Edge basic: period = 10, duty0 = 3, enable → pwm_out[0] high 3 of every 10 cycles; cycle_start every 10 cycles.
- Center: mode = 1, period = 8, duty1 = 2 → 4 high cycles per 16-cycle period, centered on cycle_start; cnt sequence 0..7,7..0.
- Glitch-free update: write duty0 = 7 mid-period (cnt = 4) → the current period keeps 3 high cycles, the next period has 7; a write coincident with B takes effect in the new period.
- Byte lanes: duty2 = 0x1234, write 0xABCD with byte_en = 2'b01 → duty2 = 0x12CD after the next boundary.
- Boundaries: duty = 0 → constant low; duty = 12 with period = 10 → constant high; period = 0 → outputs inactive and no cycle_start; polarity[3] = 1 inverts channel 3 only.
- Reset/enable: assert reset at cnt = 5 → all outputs = polarity, regs cleared; deassert enable mid-period → pwm_out inactive within 2 cycles, cnt = 0.
